// File: rtl/clock_gen_multi.sv
// Multi-channel 50%-duty clock divider with per-channel tick strobes and one
// saturating ramp channel that speeds up on ticks of a source channel.
module clock_gen_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {32'd5000000, 32'd500000, 32'd250000, 32'd2},
    parameter int RAMP_CH    = 2,
    parameter int RAMP_SRC   = 3,
    parameter int RAMP_EVERY = 1,
    parameter int RAMP_STEP  = 1000,
    parameter int RAMP_MIN   = 200000,
    parameter int RAMP_START = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              boost,
    input  logic              wr_en,
    input  logic [3:0]        wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [CNT_W-1:0]  ramp_div,
    output logic              ramp_at_min
);

    localparam int RC_W = $clog2(RAMP_EVERY + 1);
    localparam logic [CNT_W-1:0] START_V = CNT_W'(RAMP_START);
    localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(RAMP_MIN);
    localparam logic [CNT_W-1:0] STEP_V  = CNT_W'(RAMP_STEP);
    // Widened so RAMP_MIN+RAMP_STEP cannot wrap in the saturation compare
    localparam logic [CNT_W:0] FLOOR_PLUS = (CNT_W+1)'(RAMP_MIN) + (CNT_W+1)'(RAMP_STEP);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  div_d [NUM_CH];
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [RC_W-1:0]   rcnt_q, rcnt_d;
    logic              at_min_q, at_min_d;
    logic              step;
    logic              ramp_wr;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            div_d[i] = div_q[i];
        end
        clk_d   = clk_q;
        tick_d  = '0;
        rcnt_d  = rcnt_q;
        step    = 1'b0;
        ramp_wr = wr_en && (wr_ch == 4'(RAMP_CH));

        if (restart) begin
            for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
            clk_d  = '0;
            rcnt_d = '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (div_q[i] != '0) begin
                    if (cnt_q[i] >= div_q[i] - 1'b1) begin
                        cnt_d[i]  = '0;
                        clk_d[i]  = ~clk_q[i];
                        tick_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en && (wr_ch == 4'(i))) div_d[i] = wr_div;
            end

            if (tick_q[RAMP_SRC]) begin
                if (rcnt_q == RC_W'(RAMP_EVERY - 1)) begin
                    rcnt_d = '0;
                    step   = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end

            if (boost) begin
                div_d[RAMP_CH] = START_V;
                rcnt_d         = '0;
            end else if (step && !ramp_wr) begin
                if ({1'b0, div_q[RAMP_CH]} >= FLOOR_PLUS)
                    div_d[RAMP_CH] = div_q[RAMP_CH] - STEP_V;
                else
                    div_d[RAMP_CH] = MIN_V;
            end
        end

        at_min_d = (div_d[RAMP_CH] == MIN_V);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
            end
            div_q[RAMP_CH] <= START_V;
            clk_q    <= '0;
            tick_q   <= '0;
            rcnt_q   <= '0;
            at_min_q <= (START_V == MIN_V);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            rcnt_q   <= rcnt_d;
            at_min_q <= at_min_d;
        end
    end

    assign clk_out     = clk_q;
    assign tick        = tick_q;
    assign ramp_div    = div_q[RAMP_CH];
    assign ramp_at_min = at_min_q;

endmodule

// File: doc/clock_gen_multi.md
Name: clock_gen_multi

Overview:
- Parametrised successor to the game's fixed clock divider: NUM_CH independent 50%-duty divided clocks from the 50 MHz master clock, each with a one-cycle tick strobe.
- Divisors are initialised by parameter and rewritable at run time over a simple write port.
- One designated ramp channel speeds up by fixed steps on ticks of a source channel, saturates at a floor, and snaps back to its start value on a boost pulse (power-block slowdown).
- Feeds pixel, doodle, platform, points and gravity timing in the game top level.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- CNT_W, 32, divisor and counter width.
- DIV_INIT, {32'd5000000,32'd500000,32'd250000,32'd2}, packed NUM_CH*CNT_W reset divisors; channel 0 in the LSBs.
- RAMP_CH, 2, channel whose divisor ramps.
- RAMP_SRC, 3, channel whose ticks drive the ramp.
- RAMP_EVERY, 1, source ticks per ramp step (>=1).
- RAMP_STEP, 1000, divisor decrement per step.
- RAMP_MIN, 200000, divisor floor for the ramp.
- RAMP_START, 500000, ramp divisor after reset or boost.

Ports:
- clk  in  1  master clock, 50 MHz.
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk).
- restart  in  1  phase-align pulse: zero all counters and clocks.
- boost  in  1  reload the ramp divisor with RAMP_START.
- wr_en  in  1  divisor write strobe.
- wr_ch  in  4  channel index for the write.
- wr_div  in  CNT_W  new divisor value.
- clk_out  out  NUM_CH  divided clocks.
- tick  out  NUM_CH  one-cycle strobe on each clk_out toggle.
- ramp_div  out  CNT_W  current ramp-channel divisor.
- ramp_at_min  out  1  high while ramp_div == RAMP_MIN.

Behaviour:
- Everything is synchronous to posedge clk. Priority in each cycle: reset > restart > boost > write > ramp step > count.
- Reset (rst==0):
  - cnt[i]=0, clk_out=0, tick=0, ramp counter=0.
  - div[i]=DIV_INIT slice i, except div[RAMP_CH]=RAMP_START.
  - ramp_at_min=(RAMP_START==RAMP_MIN).
- Per-channel counter:
  - If div[i]==0, the channel is stalled: cnt held, clk_out held, tick=0.
  - Otherwise, if cnt[i] >= div[i]-1: cnt<=0, clk_out<=~clk_out, tick<=1 (registered, so it is high in the cycle clk_out changes).
  - Otherwise cnt<=cnt+1, tick<=0.
  - The >= compare means a shrunken divisor wraps on the next cycle with no long overrun.
  - clk_out period = 2*div cycles; div=1 gives clk/2.
- Write:
  - When wr_en=1 and wr_ch<NUM_CH, div[wr_ch]<=wr_div next cycle. wr_ch>=NUM_CH is ignored.
  - cnt and clk_out are not disturbed; the new value applies from the following compare.
  - A write to RAMP_CH also loads ramp_div.
- restart: all cnt=0, clk_out=0, tick=0, ramp counter=0. Divisors are kept.
- Ramp:
  - The ramp counter counts tick[RAMP_SRC] pulses.
  - On the pulse that makes the count reach RAMP_EVERY, the counter goes to 0 and a step occurs.
  - Step: if div[RAMP_CH] >= RAMP_MIN+RAMP_STEP then div -= RAMP_STEP; else div = RAMP_MIN (saturating, never below the floor).
  - A step is suppressed if boost or a write to RAMP_CH occurs in the same cycle.
  - If a write set div below RAMP_MIN, a step clamps it to RAMP_MIN.
- boost: div[RAMP_CH]<=RAMP_START and ramp counter<=0. Held high, it pins the ramp divisor and suppresses all steps.
- ramp_at_min is registered and tracks div[RAMP_CH] with the same latency as ramp_div.
- Arithmetic is unsigned CNT_W; comparisons use CNT_W+1 bits to avoid overflow of RAMP_MIN+RAMP_STEP.
- RAMP_SRC==RAMP_CH is legal: the channel steps off its own ticks.

Test Plan:
- Reset with NUM_CH=2, CNT_W=8, DIV_INIT={8'd3,8'd2}, no ramp activity -> ch0 toggles every 2 cycles (period 4), ch1 every 3 (period 6); tick is high exactly in the toggle cycles; all outputs are 0 while rst=0.
- Mid-count write: ch1 at cnt=5 with div=10, write div=3 -> wrap on the next cycle, then toggles every 3 cycles; clk_out never glitches twice in one cycle.
- Ramp saturation with RAMP_START=20, RAMP_STEP=4, RAMP_MIN=10, RAMP_EVERY=2 -> ramp_div goes 20,16,12,10,10 every second source tick; ramp_at_min rises on reaching 10.
- boost in the same cycle as a ramp step -> ramp_div=RAMP_START, no decrement; the next step needs RAMP_EVERY fresh source ticks.
- Write div=0 to ch0 -> clk_out[0] and tick[0] frozen; then write 2 -> resumes with period 4.
- restart pulse, then rst=0 for one cycle mid-operation -> all clocks 0 and phase-aligned the next cycle; after reset, divisors are back to DIV_INIT and RAMP_START.
